// File: rtl/adder_pkg.sv
// Shared definitions for the 4-bit adder and its downstream result FIFO.
package adder_pkg;

  localparam int OPND_W     = 4;
  localparam int SUM_W      = 7;
  localparam int FIFO_DEPTH = 8;

  typedef logic [SUM_W-1:0] sum_t;

endpackage : adder_pkg

// File: rtl/adder_fifo_mem.sv
// Register-array storage for the adder result FIFO: synchronous write,
// asynchronous read so the head entry can fall through combinationally.
module adder_fifo_mem
  import adder_pkg::*;
#(
  parameter int DATA_W = SUM_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the incoming word; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : adder_fifo_mem

// File: rtl/adder_result_fifo.sv
// Buffers adder results in a first-word-fall-through FIFO, flags dropped
// results with a sticky overflow bit and accumulates delivered results.
module adder_result_fifo
  import adder_pkg::*;
#(
  parameter int DATA_W = SUM_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int TOT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [TOT_W-1:0]  total
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;
  logic              drop;

  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // accept a push when the consumer takes an entry.
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : head;
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && !push;

  adder_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
    end
  end

  // Occupancy moves only when exactly one of push/pop happens.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Wrapping sum of every entry handed to the consumer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      total <= '0;
    end else if (pop) begin
      total <= total + {{(TOT_W - DATA_W){1'b0}}, out_data};
    end
  end

endmodule : adder_result_fifo

// File: doc/adder_result_fifo.md
Name: adder_result_fifo

Overview:
- Downstream stage of the 4-bit adder. Captures every valid 7-bit sum the adder produces and buffers it in an 8-entry first-word-fall-through FIFO.
- Presents results to the consumer over a valid/ready handshake.
- The adder has no backpressure, so this block absorbs bursts, counts stored entries and flags dropped results with a sticky overflow bit.
- Also keeps a running total of all results delivered to the consumer.

Parameters:
- DATA_W, 7, width of one adder result (4-bit + 4-bit sum, zero-extended).
- DEPTH, 8, number of FIFO entries; must be a power of two.
- ADDR_W, 3, log2(DEPTH); pointer width.
- TOT_W, 16, width of the running delivered-sum accumulator.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rstn  in  1  synchronous, active-low reset, sampled on posedge clk.
- in_valid  in  1  adder result valid this cycle.
- in_data  in  DATA_W  adder result (c).
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry this cycle.
- out_data  out  DATA_W  head entry; 0 when empty.
- count  out  ADDR_W+1  number of stored entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: a result was dropped.
- clr_ovf  in  1  clears overflow.
- total  out  TOT_W  wrapping sum of all delivered entries.

Behaviour:
- Reset (rstn==0 at posedge):
  - wr_ptr, rd_ptr, count, overflow and total all go to 0.
  - empty=1, full=0, out_valid=0, out_data=0.
  - Memory contents are not reset.
  - Reset wins over every other input, including mid-burst; all buffered entries are discarded.
- Push: occurs when in_valid && (!full || pop).
  - mem[wr_ptr] <= in_data.
  - wr_ptr increments and wraps from DEPTH-1 to 0.
- Pop: occurs when out_valid && out_ready.
  - rd_ptr increments with the same wrap.
  - total <= total + zero-extend(out_data), modulo 2^TOT_W.
- out_ready while empty has no effect.
- count:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on push+pop or on neither.
- Latency:
  - A result pushed at edge N is visible on out_valid/out_data after edge N (first-word fall-through).
  - There is no same-cycle bypass while empty.
- out_valid = !empty. out_data = mem[rd_ptr] when !empty, else 0. Both are combinational from registered state.
- Full with in_valid and a simultaneous pop: the push is accepted, count stays DEPTH, no overflow.
- Full with in_valid and no pop:
  - The result is dropped and overflow <= 1.
  - Pointers and count are unchanged.
- overflow:
  - Holds until clr_ovf=1 at a posedge.
  - If a drop and clr_ovf occur in the same cycle, the set wins and overflow stays 1.
- Ordering: strict FIFO. Pointer wrap-around must never reorder or duplicate entries.
- Widths: in_data is used as-is. total zero-extends DATA_W to TOT_W before the add, and the carry out of TOT_W is discarded.

Decomposition:
- adder_pkg holds OPND_W=4, SUM_W=7 (DATA_W default), FIFO_DEPTH=8 and the typedef sum_t (logic [SUM_W-1:0]). The adder and this block share the package.
- One sub-module, adder_fifo_mem:
  - DEPTH x DATA_W register array.
  - Synchronous write port (we, waddr, wdata) and asynchronous read port (raddr -> rdata).
  - Pointer, count, flag and total logic stay in the top block.

Test Plan:
- Reset and idle: hold rstn=0 for 2 cycles, then release with no traffic -> empty=1, full=0, count=0, out_valid=0, out_data=0, overflow=0, total=0.
- Simple pass-through: out_ready=0; push 5, 30, 0x1E on 3 consecutive cycles -> count=3. Then out_ready=1 -> out_data 5, 30, 0x1E on successive cycles, empty after the third pop, total=65.
- Fill and overflow: out_ready=0; push 1..9 on consecutive cycles -> full=1, count=8 after the 8th push. The 9th is dropped and overflow=1. Draining yields 1..8 only.
- Full with simultaneous push/pop: fill with 8 entries; one cycle with in_valid=1, in_data=0x7F, out_ready=1 -> pops 1, count stays 8, overflow stays 0. 0x7F emerges last after draining.
- Wrap-around and total: 20 cycles of alternating push/pop with values 0x40..0x53 -> output order matches input order across pointer wrap; total equals the sum of the delivered values mod 2^16. Then clr_ovf=1 clears a previously set overflow.
- Reset mid-operation: with 4 entries stored and overflow=1, assert rstn=0 for 1 cycle -> count=0, overflow=0, total=0, out_valid=0. The next push of 9 appears as out_data=9.
